// File: rtl/i2c_slave_rx.sv
// I2C write-only slave receiver: address byte, one control byte, then any
// number of data bytes. Each accepted byte is ACKed by pulling SDA low.
module i2c_slave_rx #(
   parameter logic [6:0] SLAVE_ADDR = 7'h3D
) (
   input  logic       clk2,
   input  logic       reset,
   input  logic       scl,
   input  logic       sda,
   output logic       sda_oe,
   output logic [7:0] ctrl_out,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       addr_match,
   output logic       busy
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_ACK_A = 3'd2,
      ST_CTRL  = 3'd3,
      ST_ACK_C = 3'd4,
      ST_DATA  = 3'd5,
      ST_ACK_D = 3'd6
   } state_e;

   state_e              state_q, state_d;
   logic                scl_s1_q, scl_s2_q, scl_prev_q;
   logic                sda_s1_q, sda_s2_q, sda_prev_q;
   logic [BYTE_W-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                done_q, done_d;
   logic                sda_oe_q, sda_oe_d;
   logic                match_q, match_d;
   logic [BYTE_W-1:0]   ctrl_q, ctrl_d;
   logic [BYTE_W-1:0]   data_q, data_d;
   logic                dv_q, dv_d;
   logic                busy_q, busy_d;

   logic scl_rise, scl_fall, start_ev, stop_ev;

   // Bus line synchronizers; preset high so reset looks like an idle bus
   always_ff @(posedge clk2 or negedge reset) begin
      if (!reset) begin
         scl_s1_q   <= 1'b1;
         scl_s2_q   <= 1'b1;
         scl_prev_q <= 1'b1;
         sda_s1_q   <= 1'b1;
         sda_s2_q   <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_s1_q   <= scl;
         scl_s2_q   <= scl_s1_q;
         scl_prev_q <= scl_s2_q;
         sda_s1_q   <= sda;
         sda_s2_q   <= sda_s1_q;
         sda_prev_q <= sda_s2_q;
      end
   end

   assign scl_rise = scl_s2_q & ~scl_prev_q;
   assign scl_fall = ~scl_s2_q & scl_prev_q;
   assign start_ev = scl_s2_q & scl_prev_q & ~sda_s2_q & sda_prev_q;
   assign stop_ev  = scl_s2_q & scl_prev_q & sda_s2_q & ~sda_prev_q;

   always_ff @(posedge clk2 or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         sda_oe_q <= 1'b0;
         match_q  <= 1'b0;
         ctrl_q   <= '0;
         data_q   <= '0;
         dv_q     <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         sda_oe_q <= sda_oe_d;
         match_q  <= match_d;
         ctrl_q   <= ctrl_d;
         data_q   <= data_d;
         dv_q     <= dv_d;
         busy_q   <= busy_d;
      end
   end

   // Bytes are shifted on scl_rise; the completed byte is acted on at the next scl_fall
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      done_d   = done_q;
      sda_oe_d = sda_oe_q;
      match_d  = match_q;
      ctrl_d   = ctrl_q;
      data_d   = data_q;
      dv_d     = 1'b0;

      if (start_ev) begin
         state_d  = ST_ADDR;
         cnt_d    = '0;
         done_d   = 1'b0;
         sda_oe_d = 1'b0;
         match_d  = 1'b0;
      end else if (stop_ev) begin
         state_d  = ST_IDLE;
         done_d   = 1'b0;
         sda_oe_d = 1'b0;
         match_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_ADDR, ST_CTRL, ST_DATA: begin
               if (scl_rise) begin
                  shift_d = {shift_q[BYTE_W-2:0], sda_s2_q};
                  cnt_d   = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(BYTE_W - 1)) done_d = 1'b1;
               end else if (scl_fall && done_q) begin
                  done_d = 1'b0;
                  if (state_q == ST_ADDR) begin
                     if (shift_q[7:1] == SLAVE_ADDR && !shift_q[0]) begin
                        state_d  = ST_ACK_A;
                        sda_oe_d = 1'b1;
                        match_d  = 1'b1;
                     end else begin
                        state_d = ST_IDLE;
                     end
                  end else if (state_q == ST_CTRL) begin
                     ctrl_d   = shift_q;
                     state_d  = ST_ACK_C;
                     sda_oe_d = 1'b1;
                  end else begin
                     data_d   = shift_q;
                     dv_d     = 1'b1;
                     state_d  = ST_ACK_D;
                     sda_oe_d = 1'b1;
                  end
               end
            end
            ST_ACK_A, ST_ACK_C, ST_ACK_D: begin
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  cnt_d    = '0;
                  state_d  = (state_q == ST_ACK_A) ? ST_CTRL : ST_DATA;
               end
            end
            default: ;
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   assign sda_oe     = sda_oe_q;
   assign ctrl_out   = ctrl_q;
   assign data_out   = data_q;
   assign data_valid = dv_q;
   assign addr_match = match_q;
   assign busy       = busy_q;

endmodule

// File: doc/i2c_slave_rx.md
I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

Interface
REQ-001 SHALL provide parameter SLAVE_ADDR, default 7'h3D, meaning the 7-bit target address (write byte 0x7A).
REQ-002 SHALL provide port clk2  in  1  system clock; all logic is on the rising edge.
REQ-003 SHALL provide port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL provide port scl  in  1  I2C clock from the bus, asynchronous to clk2.
REQ-005 SHALL provide port sda  in  1  I2C data from the bus, asynchronous to clk2.
REQ-006 SHALL provide port sda_oe  out  1  open-drain pull-low enable; 1 drives SDA low, 0 releases it.
REQ-007 SHALL provide port ctrl_out  out  8  last control byte received.
REQ-008 SHALL provide port data_out  out  8  last data byte received.
REQ-009 SHALL provide port data_valid  out  1  one-clk2 pulse when data_out updates.
REQ-010 SHALL provide port addr_match  out  1  high from the address ACK until the next START or STOP.
REQ-011 SHALL provide port busy  out  1  high whenever the state is not IDLE.

Function
REQ-012 SHALL pass scl and sda through 2-flop synchronizers, then hold one previous-value register per line.
REQ-013 SHALL define the bus events from synchronized values: scl_rise, scl_fall, START (scl high, sda 1->0) and STOP (scl high, sda 0->1).
REQ-014 SHALL support bus timing where SCL high and SCL low each last at least 4 clk2 cycles; shorter timing is unsupported.
REQ-015 SHALL use the states IDLE, ADDR, ACK_A, CTRL, ACK_C, DATA, ACK_D.
REQ-016 SHALL give START priority from any state: go to ADDR, clear the bit counter, set sda_oe=0 and addr_match=0.
REQ-017 SHALL, on STOP from any state, go to IDLE with sda_oe=0 and addr_match=0.
REQ-018 SHALL, in ADDR, CTRL and DATA, shift sda MSB-first into an 8-bit shift register on each scl_rise, using a 3-bit bit counter.
REQ-019 SHALL complete a byte on the 8th scl_rise; the ACK decision is acted on at the following scl_fall.
REQ-020 SHALL treat an address byte as matching when shift[7:1]==SLAVE_ADDR and shift[0]==0.
REQ-021 SHALL, on an address match, set state ACK_A and sda_oe=1 at that scl_fall, and set addr_match=1.
REQ-022 SHALL, on an address mismatch or R/W=1, go to IDLE with no ACK (sda_oe stays 0) and ignore the bus until the next START.
REQ-023 SHALL hold sda_oe=1 in ACK_A, ACK_C and ACK_D until the next scl_fall, then release it and move to the next byte state.
REQ-024 SHALL order the byte states as ACK_A->CTRL, ACK_C->DATA and ACK_D->DATA, so that unlimited data bytes are accepted.
REQ-025 SHALL, on completion of a CTRL byte, load ctrl_out, enter ACK_C and set sda_oe=1; every control byte is ACKed.
REQ-026 SHALL, on completion of a DATA byte, load data_out, pulse data_valid for exactly one clk2 cycle, enter ACK_D and set sda_oe=1.
REQ-027 SHALL assert sda_oe no later than 2 clk2 cycles after the synchronized scl_fall.
REQ-028 SHALL never toggle sda_oe while synchronized scl is high.
REQ-029 SHALL, for a partial byte ended by STOP or START, leave ctrl_out and data_out unchanged with no data_valid.
REQ-030 SHALL treat bit-counter wrap 7->0 as byte completion only; the counter is reset on START and on ACK exit.

Reset
REQ-031 SHALL, on reset low and asynchronously, set state=IDLE and sda_oe=0, data_valid=0, addr_match=0, busy=0, ctrl_out=8'h00, data_out=8'h00, shift=0 and bit counter=0.
REQ-032 SHALL, on reset low, preset the synchronizers and previous-value registers to 1 (idle bus).
REQ-033 SHALL resume from reset release in IDLE and wait for a START.

Verification
REQ-034 SHALL cover: START, 0x7A, 0x00, 0xA5, STOP -> three ACK slots with sda_oe=1, ctrl_out=0x00, data_out=0xA5, one data_valid pulse, busy=0 after STOP.
REQ-035 SHALL cover: START, 0x7C -> sda_oe stays 0 throughout, state IDLE, addr_match=0, and the following bytes are ignored.
REQ-036 SHALL cover: START, 0x7B (read) -> no ACK, IDLE, no data_valid.
REQ-037 SHALL cover: START, 0x7A, 0x00, 0x3C, 0x55, STOP -> two data_valid pulses, final data_out=0x55, four ACKs.
REQ-038 SHALL cover: START, 0x7A, 0x00, four data bits then STOP -> IDLE, data_out unchanged, no data_valid; then a repeated START with 0x7A is ACKed.
REQ-039 SHALL cover: reset asserted during ACK_C with sda_oe=1 -> sda_oe=0 immediately, all outputs at their reset values, next transaction works.
